// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART states and line-level constants
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with clear, pulses bit_tick on wrap
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            clear,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count,
    output logic                            bit_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    // Count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bit_tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer, 8N1 or 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_STOP   = STOP;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = PARITY;
    logic parity_bit;
`endif

    logic [2:0]    state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] baud_cnt;
    logic          bit_tick;
    logic          baud_clear;

    // The bit timer only runs while a frame is in flight
    assign baud_clear = (state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (baud_clear),
        .count    (baud_cnt),
        .bit_tick (bit_tick)
    );

    // Frame sequencer; tx_out is loaded with the level of the state being entered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx_out  <= IDLE_LVL;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // Look one cycle ahead so tx_done lands in the final stop-bit cycle
            tx_done <= (state == ST_STOP) && (baud_cnt == PRE_LAST);
            case (state)
                ST_IDLE: begin
                    tx_out <= IDLE_LVL;
                    if (tx_start) begin
                        shift   <= data_in;
                        bit_cnt <= '0;
                        state   <= ST_START;
                        tx_out  <= START_LVL;
                        tx_busy <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^data_in;
`endif
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state  <= ST_DATA;
                        tx_out <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state  <= ST_PARITY;
                            tx_out <= parity_bit;
`else
                            state  <= ST_STOP;
                            tx_out <= STOP_LVL;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx_out  <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        state  <= ST_STOP;
                        tx_out <= STOP_LVL;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        state   <= ST_IDLE;
                        tx_out  <= IDLE_LVL;
                        tx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx_out  <= IDLE_LVL;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmit half of the UART link. Accepts one byte per request from the host-side logic, frames it as start bit, 8 data bits LSB-first, optional even parity bit and one stop bit, and drives the serial line at a fixed baud rate. It is the far-end counterpart of the receive path's start, data, parity and stop-bit checkers. Frames it produces must pass those checkers with no errors.

## Interface
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535
- clock  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- tx_start  input  1  request to send data_in; sampled only while tx_busy=0
- data_in  input  8  byte to transmit; captured in the cycle tx_start is accepted
- tx_out  output  1  serial line; idle high
- tx_busy  output  1  high from the cycle after acceptance until frame end
- tx_done  output  1  one-cycle pulse at the end of the stop bit

## Operation
- Reset values: tx_out=1, tx_busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0.
- States: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
- IDLE:
  - tx_out=1.
  - tx_start=1 accepts the request: data_in is latched into the shift register, baud counter is cleared, and the state moves to START.
- START: tx_out=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx_out=shift[0] for CLKS_PER_BIT cycles per bit; the register shifts right after each bit.
  - A 3-bit counter runs 0..7; the state leaves DATA after bit 7.
- PARITY, when compiled in: tx_out = XOR of the latched byte (even parity).
- STOP:
  - tx_out=1 for CLKS_PER_BIT cycles.
  - In the last STOP cycle, tx_done=1. The next state is IDLE.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - The counter never free-runs in IDLE.
- tx_start while tx_busy=1 is ignored and not queued.
- data_in changes after acceptance have no effect on the frame in flight.
- Reset asserted mid-frame: tx_out returns high immediately (asynchronously), the frame is abandoned and no tx_done is produced.

## Timing
- Acceptance edge at cycle 0. tx_out falls and tx_busy rises at cycle 1; all outputs are registered.
- Frame length is 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
- tx_done is high in the cycle whose next edge returns to IDLE. tx_busy falls together with that edge.
- Back-to-back transfers:
  - With tx_start held high, the next frame is accepted in the first IDLE cycle.
  - The new start bit begins one cycle after the prior stop bit ends, so the minimum idle gap is 1 cycle.
- tx_start and tx_done high in the same cycle: tx_start is not accepted (busy); it is accepted in the next cycle if still high.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined:
  - The PARITY state is present and emits an even-parity bit between bit 7 and stop.
  - Frame = 11 bits.
- Undefined:
  - The PARITY state and XOR logic are absent and DATA goes directly to STOP.
  - Frame = 10 bits.
- Must match the receive path's parity setting.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP), 3-bit encoding;
  - constants DATA_BITS=8, START_LVL=0, STOP_LVL=1, IDLE_LVL=1.
- One sub-module, uart_baud_tick:
  - contains the CLKS_PER_BIT counter with a clear input;
  - outputs a one-cycle bit_tick on wrap.
  - Intended for reuse by the receive side.

## Test plan
- Reset with CLKS_PER_BIT=4:
  - Required during reset: tx_out=1, tx_busy=0, tx_done=0.
  - Required after release: tx_out stays 1 with no stimulus.
- Send 0xA5, no parity:
  - tx_out sequence is 0,1,0,1,0,0,1,0,1,1, each for 4 cycles.
  - tx_done pulses exactly once, at cycle 40.
  - tx_busy is high for cycles 1..40.
- Send 0x07 with UART_TX_PARITY_EN:
  - Parity bit = 1.
  - The frame is 44 cycles, and a loopback into the receive checkers reports stop_bit_error=0 with data_out=0x07.
- Collision: tx_start pulsed with 0x3C mid-frame while sending 0x81.
  - Only 0x81 is transmitted.
  - 0x3C never appears.
- Back-to-back: tx_start held high with data_in 0x55 then 0xAA.
  - Two frames are sent.
  - The gap between them is exactly 1 high cycle.
  - tx_done pulses twice.
- Reset at cycle 15 of a frame:
  - tx_out goes high asynchronously and tx_busy goes to 0.
  - No tx_done is produced.
  - A new request after release yields a correct full frame.
